taillight_decoder: RTL and testbench

TAILLIGHT_DECODER -- requirements
Module: taillight_decoder

---
 rtl/taillight_decoder_pkg.sv | 30 +++
 rtl/side_phase.sv | 22 ++
 rtl/taillight_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_taillight_decoder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taillight_decoder_pkg.sv
// Shared encodings for the taillight pattern decoder: modes, FSM states and
// the four legal single-side lamp patterns.
package taillight_decoder_pkg;

    typedef enum logic [2:0] {
        MODE_NONE    = 3'd0,
        MODE_LEFT    = 3'd1,
        MODE_RIGHT   = 3'd2,
        MODE_HAZARD  = 3'd3,
        MODE_BRAKE   = 3'd4,
        MODE_UNKNOWN = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [2:0] PAT_PH0 = 3'b000;
    localparam logic [2:0] PAT_PH1 = 3'b001;
    localparam logic [2:0] PAT_PH2 = 3'b011;
    localparam logic [2:0] PAT_PH3 = 3'b111;

    // Static modes hold one pattern instead of stepping through phases.
    function automatic logic is_static(input mode_e m);
        return (m == MODE_NONE) || (m == MODE_BRAKE);
    endfunction

endpackage

// File: rtl/side_phase.sv
// Maps one 3-bit side pattern to its legality and step phase.
module side_phase
    import taillight_decoder_pkg::*;
(
    input  logic [2:0] i_pat,
    output logic       o_legal,
    output logic [1:0] o_phase
);

    always_comb begin
        o_legal = 1'b1;
        o_phase = 2'd0;
        case (i_pat)
            PAT_PH0: o_phase = 2'd0;
            PAT_PH1: o_phase = 2'd1;
            PAT_PH2: o_phase = 2'd2;
            PAT_PH3: o_phase = 2'd3;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/taillight_decoder.sv
// Observes the six lamps on each tick, locks onto a blink mode after
// LOCK_STEPS consistent samples and counts completed sequences.
module taillight_decoder
    import taillight_decoder_pkg::*;
#(
    parameter int unsigned LOCK_STEPS = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [5:0] led,
    output logic [2:0] mode,
    output logic       valid,
    output logic       error,
    output logic [7:0] cycles
);

    localparam int unsigned       STEP_W   = $clog2(LOCK_STEPS + 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(LOCK_STEPS);

    logic              w_l_legal;
    logic              w_r_legal;
    logic [1:0]        w_l_ph;
    logic [1:0]        w_r_ph;

    state_e            r_state,    w_state;
    mode_e             r_cand,     w_cand;
    mode_e             r_mode,     w_mode;
    logic [1:0]        r_phase,    w_phase;
    logic [STEP_W-1:0] r_step_cnt, w_step_cnt;
    logic [STEP_W-1:0] r_run,      w_run;
    logic              r_run_on,   w_run_on;
    logic              r_valid,    w_valid;
    logic              r_error,    w_error;
    logic [7:0]        r_cycles,   w_cycles;

    logic              w_all_off;
    logic              w_all_on;
    logic              w_legal;
    logic              w_match;
    logic              w_seed;
    mode_e             w_seed_mode;
    logic [1:0]        w_seed_phase;
    logic [1:0]        w_exp_phase;

    side_phase u_left (
        .i_pat   (led[2:0]),
        .o_legal (w_l_legal),
        .o_phase (w_l_ph)
    );

    side_phase u_right (
        .i_pat   (led[5:3]),
        .o_legal (w_r_legal),
        .o_phase (w_r_ph)
    );

    // Classify the current sample and test it against the candidate's next step.
    always_comb begin
        w_all_off    = w_l_legal && w_r_legal && (w_l_ph == 2'd0) && (w_r_ph == 2'd0);
        w_all_on     = w_l_legal && w_r_legal && (w_l_ph == 2'd3) && (w_r_ph == 2'd3);
        w_legal      = 1'b1;
        w_seed_mode  = MODE_UNKNOWN;
        w_seed_phase = 2'd0;
        if (!w_l_legal || !w_r_legal) begin
            w_legal = 1'b0;
        end else if (w_all_off) begin
            w_seed_mode = MODE_NONE;
        end else if (w_all_on) begin
            w_seed_mode = MODE_BRAKE;
        end else if (w_r_ph == 2'd0) begin
            w_seed_mode  = MODE_LEFT;
            w_seed_phase = w_l_ph;
        end else if (w_l_ph == 2'd0) begin
            w_seed_mode  = MODE_RIGHT;
            w_seed_phase = w_r_ph;
        end else if (w_l_ph == w_r_ph) begin
            w_seed_mode  = MODE_HAZARD;
            w_seed_phase = w_l_ph;
        end else begin
            w_legal = 1'b0;
        end

        w_exp_phase = r_phase + 2'd1;
        w_match     = 1'b0;
        case (r_cand)
            MODE_LEFT:   w_match = w_legal && (w_l_ph == w_exp_phase) && (w_r_ph == 2'd0);
            MODE_RIGHT:  w_match = w_legal && (w_r_ph == w_exp_phase) && (w_l_ph == 2'd0);
            MODE_HAZARD: w_match = w_legal && (w_l_ph == w_exp_phase) && (w_r_ph == w_exp_phase);
            MODE_NONE:   w_match = w_all_off;
            MODE_BRAKE:  w_match = w_all_on;
            default:     w_match = 1'b0;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        w_state    = r_state;
        w_cand     = r_cand;
        w_mode     = r_mode;
        w_phase    = r_phase;
        w_step_cnt = r_step_cnt;
        w_run      = r_run;
        w_run_on   = r_run_on;
        w_valid    = r_valid;
        w_error    = 1'b0;
        w_cycles   = r_cycles;
        w_seed     = 1'b0;

        if (tick) begin
            // Consecutive identical all-off / all-on samples, used to seed static modes.
            w_run_on = w_all_on;
            if (w_all_off || w_all_on) begin
                if ((r_run == '0) || (r_run_on != w_all_on)) begin
                    w_run = STEP_W'(1);
                end else if (r_run < STEP_MAX) begin
                    w_run = r_run + STEP_W'(1);
                end
            end else begin
                w_run = '0;
            end

            if (!w_legal) begin
                w_state    = ST_HUNT;
                w_mode     = MODE_UNKNOWN;
                w_valid    = 1'b0;
                w_error    = 1'b1;
                w_step_cnt = '0;
                w_phase    = 2'd0;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        w_seed = 1'b1;
                    end
                    ST_TRACK: begin
                        if (w_match) begin
                            w_step_cnt = r_step_cnt + STEP_W'(1);
                            w_phase    = is_static(r_cand) ? 2'd0 : w_exp_phase;
                            if (w_step_cnt >= STEP_MAX) begin
                                w_state = ST_LOCKED;
                                w_mode  = r_cand;
                                w_valid = 1'b1;
                            end
                        end else begin
                            w_seed = 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_match) begin
                            w_phase = w_exp_phase;
                            if (r_phase == 2'd3) begin
                                w_cycles = r_cycles + 8'd1;
                            end
                        end else begin
                            w_seed  = 1'b1;
                            w_error = 1'b1;
                            w_mode  = MODE_UNKNOWN;
                            w_valid = 1'b0;
                        end
                    end
                    default: begin
                        w_state = ST_HUNT;
                    end
                endcase

                if (w_seed) begin
                    w_state    = ST_TRACK;
                    w_cand     = w_seed_mode;
                    w_phase    = is_static(w_seed_mode) ? 2'd0 : w_seed_phase;
                    w_step_cnt = is_static(w_seed_mode) ? w_run : STEP_W'(1);
                    w_cycles   = 8'd0;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_HUNT;
            r_cand     <= MODE_NONE;
            r_mode     <= MODE_NONE;
            r_phase    <= 2'd0;
            r_step_cnt <= '0;
            r_run      <= '0;
            r_run_on   <= 1'b0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_cycles   <= 8'd0;
        end else begin
            r_state    <= w_state;
            r_cand     <= w_cand;
            r_mode     <= w_mode;
            r_phase    <= w_phase;
            r_step_cnt <= w_step_cnt;
            r_run      <= w_run;
            r_run_on   <= w_run_on;
            r_valid    <= w_valid;
            r_error    <= w_error;
            r_cycles   <= w_cycles;
        end
    end

    assign mode   = r_mode;
    assign valid  = r_valid;
    assign error  = r_error;
    assign cycles = r_cycles;

endmodule

// File: tb/tb_taillight_decoder.sv
// Directed-vector bench for taillight_decoder with a pattern-table reference
// model compared every cycle, plus literal checkpoints.
module tb_taillight_decoder;

    localparam int LOCK = 4;

    logic       CLOCK_50;
    logic       reset_n = 1'b0;
    logic       tick    = 1'b0;
    logic [5:0] led     = 6'h00;
    logic [2:0] mode;
    logic       valid;
    logic       error;
    logic [7:0] cycles;

    int total = 0;
    int bad   = 0;

    taillight_decoder #(.LOCK_STEPS(LOCK)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .tick     (tick),
        .led      (led),
        .mode     (mode),
        .valid    (valid),
        .error    (error),
        .cycles   (cycles)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    typedef struct packed {
        logic [1:0] st;     // 0 hunt, 1 track, 2 locked
        logic [2:0] cand;
        logic [1:0] ph;
        logic [2:0] scnt;
        logic [3:0] steps;
        logic [3:0] run;
        logic [5:0] last;
        logic [2:0] mode;
        logic       valid;
        logic       err;
        logic [7:0] cyc;
    } mdl_t;

    mdl_t m;

    // Full six-lamp image of a mode at a given phase.
    function automatic logic [5:0] pat(input int md, input int ph);
        logic [2:0] s;
        case (ph)
            0:       s = 3'b000;
            1:       s = 3'b001;
            2:       s = 3'b011;
            default: s = 3'b111;
        endcase
        case (md)
            1:       return {3'b000, s};
            2:       return {s, 3'b000};
            3:       return {s, s};
            4:       return 6'h3f;
            default: return 6'h00;
        endcase
    endfunction

    function automatic void classify(input logic [5:0] l, output int md, output int ph);
        md = -1;
        ph = 0;
        if (l == 6'h00) md = 0;
        else if (l == 6'h3f) md = 4;
        else begin
            for (int mm = 1; mm <= 3; mm++)
                for (int pp = 1; pp <= 3; pp++)
                    if (pat(mm, pp) == l) begin
                        md = mm;
                        ph = pp;
                    end
        end
    endfunction

    function automatic mdl_t next_model(input mdl_t s, input logic [5:0] l);
        mdl_t n;
        int   md, ph;
        logic stat_c, stat_s, match;
        n     = s;
        n.err = 1'b0;
        if (l == 6'h00 || l == 6'h3f) begin
            if (s.run != 4'd0 && s.last == l) n.run = (s.run < 4'(LOCK)) ? s.run + 4'd1 : s.run;
            else n.run = 4'd1;
            n.last = l;
        end else begin
            n.run = 4'd0;
        end
        classify(l, md, ph);
        if (md < 0) begin
            n.st = 2'd0; n.mode = 3'd7; n.valid = 1'b0; n.err = 1'b1;
            n.steps = 4'd0; n.ph = 2'd0;
            return n;
        end
        stat_c = (s.cand == 3'd0) || (s.cand == 3'd4);
        match  = (s.st != 2'd0) &&
                 (l == (stat_c ? pat(int'(s.cand), 0) : pat(int'(s.cand), (int'(s.ph) + 1) % 4)));
        if (match && s.st == 2'd2) begin
            if (stat_c) begin
                n.scnt = s.scnt + 3'd1;
                if (n.scnt == 3'd4) begin
                    n.scnt = 3'd0;
                    n.cyc  = s.cyc + 8'd1;
                end
            end else begin
                n.ph = 2'((int'(s.ph) + 1) % 4);
                if (n.ph == 2'd0) n.cyc = s.cyc + 8'd1;
            end
        end else if (match) begin
            n.steps = s.steps + 4'd1;
            n.ph    = stat_c ? 2'd0 : 2'((int'(s.ph) + 1) % 4);
            if (int'(n.steps) >= LOCK) begin
                n.st = 2'd2; n.mode = s.cand; n.valid = 1'b1; n.scnt = 3'd0;
            end
        end else begin
            if (s.st == 2'd2) begin
                n.err = 1'b1; n.mode = 3'd7; n.valid = 1'b0;
            end
            stat_s  = (md == 0) || (md == 4);
            n.st    = 2'd1;
            n.cand  = 3'(md);
            n.ph    = stat_s ? 2'd0 : 2'(ph);
            n.steps = stat_s ? n.run : 4'd1;
            n.cyc   = 8'd0;
            n.scnt  = 3'd0;
        end
        return n;
    endfunction

    always @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else if (tick) m <= next_model(m, led);
        else m.err <= 1'b0;
    end

    // Every-cycle comparison against the model.
    always @(negedge CLOCK_50) begin
        total++;
        if (mode !== m.mode || valid !== m.valid || error !== m.err || cycles !== m.cyc) begin
            bad++;
            $display("FAIL model_cmp t=%0t dut mode=%0d valid=%b error=%b cycles=%0d model mode=%0d valid=%b error=%b cycles=%0d",
                     $time, mode, valid, error, cycles, m.mode, m.valid, m.err, m.cyc);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_tick(input logic [5:0] v);
        @(negedge CLOCK_50);
        tick = 1'b1;
        led  = v;
        @(negedge CLOCK_50);
        tick = 1'b0;
        led  = 6'($urandom);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            tick = 1'b0;
            led  = 6'($urandom);
        end
    endtask

    logic [2:0] ill [4];

    initial begin
        ill = '{3'b010, 3'b100, 3'b101, 3'b110};
        repeat (3) @(negedge CLOCK_50);
        chk("rst_mode",   int'(mode),   0);
        chk("rst_valid",  int'(valid),  0);
        chk("rst_error",  int'(error),  0);
        chk("rst_cycles", int'(cycles), 0);
        reset_n = 1'b1;

        // Left sequence locks on the 4th tick; next 111->000 completes a cycle.
        do_tick(6'b000001); do_tick(6'b000011); do_tick(6'b000111);
        chk("left_pre_valid", int'(valid), 0);
        do_tick(6'b000000);
        chk("left_valid", int'(valid), 1);
        chk("left_mode",  int'(mode),  1);
        do_tick(6'b000001); do_tick(6'b000011); do_tick(6'b000111);
        chk("left_cyc0", int'(cycles), 0);
        do_tick(6'b000000);
        chk("left_cyc1", int'(cycles), 1);

        // Skipped step while locked: error, re-seed, re-lock after 3 ticks.
        do_tick(6'b000001);
        do_tick(6'b000111);
        chk("skip_err",   int'(error), 1);
        chk("skip_valid", int'(valid), 0);
        chk("skip_mode",  int'(mode),  7);
        gap(1);
        chk("skip_err_pulse", int'(error), 0);
        do_tick(6'b000000); do_tick(6'b000001);
        chk("skip_pre_relock", int'(valid), 0);
        do_tick(6'b000011);
        chk("skip_relock", int'(valid), 1);
        chk("skip_cyc",    int'(cycles), 0);

        // 1024 left steps from phase 2: cycles wraps after 256 sequences.
        for (int k = 1; k <= 1024; k++) begin
            do_tick(pat(1, (2 + k) % 4));
            chk("wrap_valid", int'(valid), 1);
            if (k == 1021) chk("wrap_255", int'(cycles), 255);
        end
        chk("wrap_0", int'(cycles), 0);

        // Right lock, then illegal right-side 010.
        do_tick(6'b001000); do_tick(6'b011000); do_tick(6'b111000); do_tick(6'b000000);
        chk("right_mode",  int'(mode),  2);
        chk("right_valid", int'(valid), 1);
        do_tick(6'b010000);
        chk("ill_err",   int'(error), 1);
        chk("ill_mode",  int'(mode),  7);
        chk("ill_valid", int'(valid), 0);
        gap(1);
        chk("ill_err_pulse", int'(error), 0);

        // Hazard reaches 111111 without becoming BRAKE; held 111111 re-locks as BRAKE.
        do_tick(6'b001001); do_tick(6'b011011); do_tick(6'b111111);
        chk("haz_not_brake", int'(mode), 7);
        do_tick(6'b000000);
        chk("haz_mode",  int'(mode),  3);
        chk("haz_valid", int'(valid), 1);
        do_tick(6'h3f);
        chk("brk_err",  int'(error), 1);
        chk("brk_mode7", int'(mode), 7);
        do_tick(6'h3f); do_tick(6'h3f);
        chk("brk_pre_valid", int'(valid), 0);
        do_tick(6'h3f);
        chk("brk_mode",  int'(mode),  4);
        chk("brk_valid", int'(valid), 1);
        do_tick(6'h3f); do_tick(6'h3f); do_tick(6'h3f);
        chk("brk_cyc0", int'(cycles), 0);
        do_tick(6'h3f);
        chk("brk_cyc1", int'(cycles), 1);

        // All-off: NONE after LOCK consecutive all-off ticks.
        do_tick(6'h00); do_tick(6'h00); do_tick(6'h00); do_tick(6'h00);
        chk("none_mode",  int'(mode),  0);
        chk("none_valid", int'(valid), 1);
        do_tick(6'b000001); do_tick(6'b000011); do_tick(6'b000111); do_tick(6'h00);
        chk("amb_left", int'(mode), 1);
        do_tick(6'h00); do_tick(6'h00);
        chk("amb_pre_none", int'(valid), 0);
        do_tick(6'h00);
        chk("amb_none_valid", int'(valid), 1);
        chk("amb_none_mode",  int'(mode),  0);

        // Reset pulse mid-TRACK clears outputs immediately.
        do_tick(6'b000001);
        chk("pre_rst_mode", int'(mode), 7);
        #2 reset_n = 1'b0;
        #1;
        chk("async_mode",   int'(mode),   0);
        chk("async_error",  int'(error),  0);
        chk("async_valid",  int'(valid),  0);
        chk("async_cycles", int'(cycles), 0);
        @(negedge CLOCK_50);
        #2 reset_n = 1'b1;

        // First tick after release is a fresh HUNT sample; led noise between ticks.
        do_tick(6'b000011); gap(2);
        do_tick(6'b000111); gap(3);
        do_tick(6'b000000); gap(1);
        chk("post_rst_pre", int'(valid), 0);
        do_tick(6'b000001);
        chk("post_rst_valid", int'(valid), 1);
        chk("post_rst_mode",  int'(mode),  1);

        // Each illegal left-side pattern flags an error.
        for (int i = 0; i < 4; i++) begin
            do_tick({3'b000, ill[i]});
            chk("ill_left_err",  int'(error), 1);
            chk("ill_left_mode", int'(mode),  7);
        end
        gap(1);
        chk("ill_left_clear", int'(error), 0);

        gap(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
